axi_async_src_ctrl: RTL and testbench

AXI_ASYNC_SRC_CTRL -- requirements
Module: axi_async_src_ctrl

---
 rtl/axi_async_pkg.sv | 22 ++
 rtl/axi_async_sync.sv | 25 ++
 rtl/axi_async_src_ctrl.sv | 84 ++++++++
 tb/tb_axi_async_src_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_async_pkg.sv
// axi_async_pkg: shared width helpers and BUFFER_WIDTH limits for the async AXI token-ring controllers
package axi_async_pkg;

    localparam int MIN_BUFFER_WIDTH = 2;
    localparam int MAX_BUFFER_WIDTH = 16;

    typedef logic [$clog2(MAX_BUFFER_WIDTH)-1:0]   idx_t;
    typedef logic [$clog2(MAX_BUFFER_WIDTH+1)-1:0] fill_t;

    function automatic int idx_width(input int bw);
        return $clog2(bw);
    endfunction

    function automatic int fill_width(input int bw);
        return $clog2(bw + 1);
    endfunction

    function automatic bit buffer_width_legal(input int bw);
        return bw >= MIN_BUFFER_WIDTH && bw <= MAX_BUFFER_WIDTH;
    endfunction

endpackage

// File: rtl/axi_async_sync.sv
// axi_async_sync: two-flop per-bit synchroniser, cleared to 0 on reset
module axi_async_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] s1_q, s2_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/axi_async_src_ctrl.sv
// axi_async_src_ctrl: source-side slot writer and write-token owner for one channel of a token-ring async FIFO
module axi_async_src_ctrl
    import axi_async_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int BUFFER_WIDTH = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 valid_i,
    input  logic [DATA_WIDTH-1:0]                data_i,
    output logic                                 ready_o,
    output logic [BUFFER_WIDTH*DATA_WIDTH-1:0]   buf_data_o,
    output logic [BUFFER_WIDTH-1:0]              writetoken_o,
    input  logic [BUFFER_WIDTH-1:0]              readpointer_i,
    output logic [fill_width(BUFFER_WIDTH)-1:0]  fill_o
);

    localparam int IW = idx_width(BUFFER_WIDTH);
    localparam int FW = fill_width(BUFFER_WIDTH);

    if (!buffer_width_legal(BUFFER_WIDTH)) begin : g_illegal_width
        $error("axi_async_src_ctrl: BUFFER_WIDTH must be within 2..16");
    end

    logic [BUFFER_WIDTH-1:0][DATA_WIDTH-1:0] buf_q, buf_d;
    logic [BUFFER_WIDTH-1:0]                 writetoken_q, writetoken_d;
    logic [BUFFER_WIDTH-1:0]                 rp_sync, rp_prev_q, pend_mask, occupied;
    logic [IW-1:0]                           wr_idx_q, wr_idx_d, pend_idx_q, pend_idx_d;
    logic                                    pend_q, pend_d, accept;

    axi_async_sync #(.WIDTH(BUFFER_WIDTH)) i_rp_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (readpointer_i),
        .q_o    (rp_sync)
    );

    // A slot whose token toggle is still pending counts as occupied so it cannot be rewritten.
    assign pend_mask    = pend_q ? BUFFER_WIDTH'(1) << pend_idx_q : '0;
    assign occupied     = (writetoken_q ^ rp_sync) | pend_mask;
    assign ready_o      = ~occupied[wr_idx_q];
    assign accept       = valid_i & ready_o;
    assign fill_o       = FW'($countones(writetoken_q ^ rp_sync)) + FW'(pend_q);
    assign writetoken_o = writetoken_q;
    assign buf_data_o   = buf_q;

    assign writetoken_d = writetoken_q ^ pend_mask;
    assign pend_d       = accept;
    assign pend_idx_d   = accept ? wr_idx_q : pend_idx_q;
    assign wr_idx_d     = !accept ? wr_idx_q : wr_idx_q == IW'(BUFFER_WIDTH - 1) ? '0 : wr_idx_q + 1'b1;

    always_comb begin
        buf_d = buf_q;
        if (accept) buf_d[wr_idx_q] = data_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            buf_q        <= '0;
            writetoken_q <= '0;
            wr_idx_q     <= '0;
            pend_q       <= 1'b0;
            pend_idx_q   <= '0;
            rp_prev_q    <= '0;
        end else begin
            buf_q        <= buf_d;
            writetoken_q <= writetoken_d;
            wr_idx_q     <= wr_idx_d;
            pend_q       <= pend_d;
            pend_idx_q   <= pend_idx_d;
            rp_prev_q    <= rp_sync;
        end
    end

    // The remote side may only hand back a slot it was given; anything else is a protocol error.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (((rp_sync ^ rp_prev_q) & ~(writetoken_q ^ rp_prev_q)) == '0)
                else $error("axi_async_src_ctrl: readpointer toggled on a free slot");
        end
    end

endmodule

// File: tb/tb_axi_async_src_ctrl.sv
// tb_axi_async_src_ctrl: directed scenarios checked every cycle against a slot-level model of the token ring
module tb_axi_async_src_ctrl;

    localparam int DW = 8;
    localparam int BW = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              valid = 1'b0;
    logic [DW-1:0]     data = '0;
    logic              ready;
    logic [BW*DW-1:0]  buf_data;
    logic [BW-1:0]     wtok;
    logic [BW-1:0]     rp = '0;
    logic [2:0]        fill;
    int                checks = 0;
    int                errors = 0;
    bit                cmp_en = 1'b0;

    axi_async_src_ctrl #(.DATA_WIDTH(DW), .BUFFER_WIDTH(BW)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .valid_i       (valid),
        .data_i        (data),
        .ready_o       (ready),
        .buf_data_o    (buf_data),
        .writetoken_o  (wtok),
        .readpointer_i (rp),
        .fill_o        (fill)
    );

    always #5 clk = ~clk;

    // Model: per-slot token and payload, readpointer seen through a two-sample delay line.
    int m_tok[BW];
    int m_slot[BW];
    int m_rs1[BW];
    int m_rs2[BW];
    int m_wr = 0;
    int m_pend = -1;

    function automatic bit m_occ(input int k);
        return m_tok[k] != m_rs2[k] || m_pend == k;
    endfunction

    function automatic int m_fill();
        int n = 0;
        for (int k = 0; k < BW; k++) n += m_tok[k] != m_rs2[k] ? 1 : 0;
        return n + (m_pend >= 0 ? 1 : 0);
    endfunction

    function automatic logic [BW-1:0] m_wtok();
        logic [BW-1:0] v;
        for (int k = 0; k < BW; k++) v[k] = m_tok[k] != 0;
        return v;
    endfunction

    function automatic logic [BW*DW-1:0] m_buf();
        logic [BW*DW-1:0] v;
        for (int k = 0; k < BW; k++) v[k*DW +: DW] = DW'(m_slot[k]);
        return v;
    endfunction

    always @(posedge clk) begin
        bit acc;
        if (!rst_n) begin
            for (int k = 0; k < BW; k++) begin
                m_tok[k] = 0;
                m_slot[k] = 0;
                m_rs1[k] = 0;
                m_rs2[k] = 0;
            end
            m_wr = 0;
            m_pend = -1;
        end else begin
            acc = valid && !m_occ(m_wr);
            if (m_pend >= 0) m_tok[m_pend] = 1 - m_tok[m_pend];
            m_pend = -1;
            if (acc) begin
                m_slot[m_wr] = int'(data);
                m_pend = m_wr;
                m_wr = (m_wr + 1) % BW;
            end
            for (int k = 0; k < BW; k++) begin
                m_rs2[k] = m_rs1[k];
                m_rs1[k] = int'(rp[k]);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Hand-computed values pin both the DUT and the model.
    task automatic lit(input string name, input logic [63:0] dut_v, input logic [63:0] mdl_v, input logic [63:0] exp);
        chk({name, "_dut"}, dut_v, exp);
        chk({name, "_model"}, mdl_v, exp);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ready", 64'(ready), 64'(!m_occ(m_wr)));
            chk("fill", 64'(fill), 64'(m_fill()));
            chk("writetoken", 64'(wtok), 64'(m_wtok()));
            chk("buf_data", 64'(buf_data), 64'(m_buf()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rp = '0;
        valid = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic beat(input logic [DW-1:0] d);
        valid = 1'b1;
        data = d;
        step();
        valid = 1'b0;
        data = '0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        step();
        cmp_en = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        lit("post_reset_ready", 64'(ready), 64'(!m_occ(m_wr)), 1);
        lit("post_reset_fill", 64'(fill), 64'(m_fill()), 0);
        lit("post_reset_wtok", 64'(wtok), 64'(m_wtok()), 0);

        beat(8'hA5);
        lit("single_slot0", 64'(buf_data[7:0]), 64'(m_slot[0]), 64'hA5);
        lit("single_wtok_e1", 64'(wtok), 64'(m_wtok()), 0);
        lit("single_fill_e1", 64'(fill), 64'(m_fill()), 1);
        step();
        lit("single_wtok_e2", 64'(wtok), 64'(m_wtok()), 4'b0001);
        lit("single_fill_e2", 64'(fill), 64'(m_fill()), 1);

        do_reset();
        for (int i = 1; i <= 4; i++) begin
            valid = 1'b1;
            data = DW'(i);
            step();
        end
        data = 8'hEE;
        lit("full_ready", 64'(ready), 64'(!m_occ(m_wr)), 0);
        lit("full_fill_a", 64'(fill), 64'(m_fill()), 4);
        step();
        step();
        step();
        valid = 1'b0;
        data = '0;
        lit("full_wtok", 64'(wtok), 64'(m_wtok()), 4'b1111);
        lit("full_fill", 64'(fill), 64'(m_fill()), 4);
        lit("full_buf", 64'(buf_data), 64'(m_buf()), 32'h04030201);

        rp = 4'b0001;
        step();
        lit("free_not_early", 64'(ready), 64'(!m_occ(m_wr)), 0);
        n = 1;
        while (!ready && n < 3) begin
            step();
            n++;
        end
        lit("free_ready", 64'(ready), 64'(!m_occ(m_wr)), 1);
        beat(8'h05);
        lit("wrap_slot0", 64'(buf_data[7:0]), 64'(m_slot[0]), 64'h05);
        step();
        lit("wrap_wtok", 64'(wtok), 64'(m_wtok()), 4'b1110);
        lit("wrap_buf", 64'(buf_data), 64'(m_buf()), 32'h04030205);
        lit("wrap_fill", 64'(fill), 64'(m_fill()), 4);

        do_reset();
        beat(8'h11);
        beat(8'h22);
        step();
        lit("simul_pre_fill", 64'(fill), 64'(m_fill()), 2);
        lit("simul_pre_wtok", 64'(wtok), 64'(m_wtok()), 4'b0011);
        rp = 4'b0001;
        step();
        beat(8'h33);
        lit("simul_fill_e0", 64'(fill), 64'(m_fill()), 2);
        step();
        lit("simul_fill_e1", 64'(fill), 64'(m_fill()), 2);
        lit("simul_wtok", 64'(wtok), 64'(m_wtok()), 4'b0111);
        lit("simul_slot2", 64'(buf_data[23:16]), 64'(m_slot[2]), 64'h33);

        beat(8'h44);
        step();
        lit("midrst_pre_fill", 64'(fill), 64'(m_fill()), 3);
        rst_n = 1'b0;
        rp = '0;
        step();
        lit("midrst_ready", 64'(ready), 64'(!m_occ(m_wr)), 1);
        lit("midrst_fill", 64'(fill), 64'(m_fill()), 0);
        lit("midrst_wtok", 64'(wtok), 64'(m_wtok()), 0);
        lit("midrst_buf", 64'(buf_data), 64'(m_buf()), 0);
        rst_n = 1'b1;
        step();
        step();
        beat(8'h77);
        step();
        lit("after_rst_wtok", 64'(wtok), 64'(m_wtok()), 4'b0001);
        lit("after_rst_buf", 64'(buf_data), 64'(m_buf()), 32'h00000077);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
